// File: rtl/conv_enc_ctrl.sv
// conv_enc_ctrl: sequencer for the bit-serial tail-biting convolutional encoder.
//
// Pops one block descriptor {size_flag, tail[5:0]}, pulses enc_init so the
// encoder preloads its memory with the tail bits, then streams the block's
// data bytes LSB first, one bit per enc_step, until SMALL_SIZE or LARGE_SIZE
// bits have been stepped. Back-pressure from the output side (out_afull)
// and an empty byte FIFO both stall stepping without losing state.
//
// Optional feature (compile-time macro CONV_ENC_CTRL_TAIL_CHECK_EN):
//   adds output tail_err, which pulses with blk_done when the last six
//   stepped bits differ from the latched tail.
//
// Handshake: both FIFOs are show-ahead. *_empty=0 means *_data is valid now;
// raising *_rdreq in the same cycle consumes that word at the next rising
// clk edge. rdreq is never raised while the matching empty is high, and both
// rdreqs are held low while reset is asserted.
//
// state_dbg exposes the FSM state (0 IDLE, 1 INIT, 2 RUN, 3 DONE).

module conv_enc_ctrl #(
  parameter int SMALL_SIZE = 1056,
  parameter int LARGE_SIZE = 6144,
  parameter int CNT_W      = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             desc_empty,
  input  logic [6:0]       desc_data,
  output logic             desc_rdreq,
  input  logic             blk_empty,
  input  logic [7:0]       blk_data,
  output logic             blk_rdreq,
  input  logic             out_afull,
  output logic             enc_init,
  output logic [5:0]       enc_tail,
  output logic             enc_step,
  output logic             enc_bit,
  output logic             enc_last,
  output logic             blk_done,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
`ifdef CONV_ENC_CTRL_TAIL_CHECK_EN
  output logic             tail_err,
`endif
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Index of the final bit of each block size; compared against the number
  // of bits already stepped so enc_last rises on the final step itself.
  localparam logic [CNT_W-1:0] SMALL_LAST = CNT_W'(SMALL_SIZE - 1);
  localparam logic [CNT_W-1:0] LARGE_LAST = CNT_W'(LARGE_SIZE - 1);

  state_t           state_q;
  state_t           state_d;
  logic [2:0]       bit_idx_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             size_flag_q;
  logic [5:0]       tail_q;
  logic [CNT_W-1:0] last_idx;

  assign last_idx = size_flag_q ? LARGE_LAST : SMALL_LAST;

  // Next-state and control outputs; everything is gated by reset so no FIFO
  // is popped and no encoder control fires while reset is held.
  always_comb begin
    state_d    = state_q;
    desc_rdreq = 1'b0;
    blk_rdreq  = 1'b0;
    enc_init   = 1'b0;
    enc_step   = 1'b0;
    enc_bit    = 1'b0;
    enc_last   = 1'b0;
    blk_done   = 1'b0;
    if (reset) begin
      case (state_q)
        ST_IDLE: begin
          desc_rdreq = !desc_empty;
          if (!desc_empty) begin
            state_d = ST_INIT;
          end
        end
        ST_INIT: begin
          enc_init = 1'b1;
          state_d  = ST_RUN;
        end
        ST_RUN: begin
          // enc_bit follows the FIFO head; only meaningful when stepping.
          enc_bit   = blk_data[bit_idx_q];
          enc_step  = !blk_empty && !out_afull;
          // Pop the byte together with its 8th (MSB) bit.
          blk_rdreq = enc_step && (bit_idx_q == 3'd7);
          enc_last  = enc_step && (bit_cnt_q == last_idx);
          if (enc_last) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          blk_done = 1'b1;
          state_d  = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Descriptor latch plus bit position/count tracking. Stalls hold both
  // counters; bit_idx wraps 7->0 naturally in three bits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      size_flag_q <= 1'b0;
      tail_q      <= 6'd0;
      bit_idx_q   <= 3'd0;
      bit_cnt_q   <= '0;
    end else begin
      if (desc_rdreq) begin
        size_flag_q <= desc_data[6];
        tail_q      <= desc_data[5:0];
      end
      if (enc_init) begin
        bit_idx_q <= 3'd0;
        bit_cnt_q <= '0;
      end else if (enc_step) begin
        bit_idx_q <= bit_idx_q + 3'd1;
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef CONV_ENC_CTRL_TAIL_CHECK_EN
  logic [5:0] tail_sr_q;

  // Remember the last six stepped bits: newest enters bit 5, so after the
  // final step bit 5 holds block bit K-1 and bit 0 holds bit K-6, matching
  // the layout of the descriptor's tail field.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tail_sr_q <= 6'd0;
    end else if (enc_init) begin
      tail_sr_q <= 6'd0;
    end else if (enc_step) begin
      tail_sr_q <= {enc_bit, tail_sr_q[5:1]};
    end
  end

  // A mismatch means the descriptor's tail does not describe this block, so
  // the tail-biting start state was wrong.
  always_comb begin
    tail_err = blk_done && (tail_sr_q != tail_q);
  end
`endif

  // Registered status straight out; busy is gated so it reads 0 in reset.
  always_comb begin
    enc_tail  = tail_q;
    bit_cnt   = bit_cnt_q;
    busy      = reset && (state_q != ST_IDLE);
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_conv_enc_ctrl.sv
// tb_conv_enc_ctrl: directed, table-driven bench for conv_enc_ctrl.
// Each table row describes one block (descriptor, fill byte, optional stall
// window) together with hand-computed step/pop counts and block timing.
// Show-ahead FIFOs are modelled with queues; every block is checked for
// bit order, pop alignment, init/last/done timing and counter tracking.

module tb_conv_enc_ctrl;

  localparam int CNT_W = 13;

  logic             clk;
  logic             reset;
  logic             desc_empty;
  logic [6:0]       desc_data;
  logic             desc_rdreq;
  logic             blk_empty;
  logic [7:0]       blk_data;
  logic             blk_rdreq;
  logic             out_afull;
  logic             enc_init;
  logic [5:0]       enc_tail;
  logic             enc_step;
  logic             enc_bit;
  logic             enc_last;
  logic             blk_done;
  logic             busy;
  logic [CNT_W-1:0] bit_cnt;
  logic [1:0]       state_dbg;
`ifdef CONV_ENC_CTRL_TAIL_CHECK_EN
  logic             tail_err;
`endif

  conv_enc_ctrl #(
    .SMALL_SIZE(1056),
    .LARGE_SIZE(6144),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .desc_empty(desc_empty),
    .desc_data(desc_data),
    .desc_rdreq(desc_rdreq),
    .blk_empty(blk_empty),
    .blk_data(blk_data),
    .blk_rdreq(blk_rdreq),
    .out_afull(out_afull),
    .enc_init(enc_init),
    .enc_tail(enc_tail),
    .enc_step(enc_step),
    .enc_bit(enc_bit),
    .enc_last(enc_last),
    .blk_done(blk_done),
    .busy(busy),
    .bit_cnt(bit_cnt),
`ifdef CONV_ENC_CTRL_TAIL_CHECK_EN
    .tail_err(tail_err),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- FIFO models / scoreboard state ----------------
  logic [6:0] desc_q[$];
  logic [7:0] byte_q[$];
  logic       rst_drive;
  logic       force_empty;
  logic       force_afull;
  int         cyc;
  int         last_done_cyc;
  int         n_tests;
  int         n_fail;

  typedef struct {
    logic       size_flag;
    logic [5:0] tail;
    logic [7:0] fill;
    int         gap_kind;     // 0 none, 1 forced empty, 2 out_afull
    int         gap_at;       // steps completed when the stall window opens
    int         gap_len;
    int         exp_steps;
    int         exp_pops;
    int         exp_done_off; // cycles from descriptor pop to blk_done
    logic       exp_tail_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // One clock: drive inputs at the falling edge, sample outputs 1 time unit
  // later, then apply the pops that the next rising edge commits.
  task automatic cycle();
    @(negedge clk);
    reset      = rst_drive;
    desc_empty = (desc_q.size() == 0);
    desc_data  = desc_empty ? 7'h00 : desc_q[0];
    blk_empty  = force_empty || (byte_q.size() == 0);
    blk_data   = (byte_q.size() == 0) ? 8'h00 : byte_q[0];
    out_afull  = force_afull;
    #1;
    if (desc_rdreq && desc_q.size() > 0) desc_q.delete(0);
    if (blk_rdreq && byte_q.size() > 0) byte_q.delete(0);
    cyc++;
  endtask

  task automatic push_block(input int idx);
    desc_q.push_back({vecs[idx].size_flag, vecs[idx].tail});
    for (int i = 0; i < vecs[idx].exp_steps / 8; i++) byte_q.push_back(vecs[idx].fill);
  endtask

  // Reset asserted for one cycle mid-block, then outputs checked the cycle after.
  task automatic do_abort(input int pops_so_far);
    chk("abort_pops_before_reset", pops_so_far, 62);
    rst_drive = 1'b0;
    cycle();
    chk("abort_desc_rdreq_in_reset", desc_rdreq, 0);
    chk("abort_blk_rdreq_in_reset", blk_rdreq, 0);
    rst_drive = 1'b1;
    cycle();
    chk("abort_state_idle", state_dbg, 0);
    chk("abort_busy", busy, 0);
    chk("abort_bit_cnt", bit_cnt, 0);
    chk("abort_enc_tail", enc_tail, 0);
    chk("abort_enc_step", enc_step, 0);
    chk("abort_blk_rdreq", blk_rdreq, 0);
    chk("abort_desc_rdreq", desc_rdreq, 0);
    chk("abort_ctrl_pulses", {enc_init, enc_bit, enc_last, blk_done}, 0);
    byte_q.delete();
  endtask

  task automatic run_block(input int idx, input bit do_push, input bit b2b, input int abort_at);
    vec_t             v;
    logic [7:0]       fb;
    int               steps, pops, init_cnt, init_err, tail_bad, bit_err, pop_err;
    int               last_cnt, last_step, busy_err, cnt_err, gap_err, hold_err;
    int               gap_left, budget, pop_cyc, offset, done_off;
    bit               popped, gap_started, done_seen;
    logic             done_desc_rd, done_last, done_terr;
    logic [CNT_W-1:0] done_cnt;
    v = vecs[idx];
    fb = v.fill;
    if (do_push) push_block(idx);
    steps = 0; pops = 0; init_cnt = 0; init_err = 0; tail_bad = 0; bit_err = 0;
    pop_err = 0; last_cnt = 0; last_step = -1; busy_err = 0; cnt_err = 0;
    gap_err = 0; hold_err = 0; gap_left = 0; pop_cyc = 0; done_off = -1;
    popped = 0; gap_started = 0; done_seen = 0;
    done_desc_rd = 1'b0; done_last = 1'b0; done_terr = 1'b0; done_cnt = '0;
    budget = v.exp_done_off + 64;
    while (!done_seen && budget > 0) begin
      budget--;
      if (v.gap_kind != 0 && !gap_started && steps == v.gap_at) begin
        gap_started = 1;
        gap_left    = v.gap_len;
      end
      force_empty = (v.gap_kind == 1) && (gap_left > 0);
      force_afull = (v.gap_kind == 2) && (gap_left > 0);
      cycle();
      if (!popped) begin
        if (desc_rdreq) begin
          popped  = 1;
          pop_cyc = cyc;
          chk("busy_low_at_pop", busy, 0);
          if (b2b) chk("b2b_done_to_pop", pop_cyc - last_done_cyc, 1);
        end
        continue;
      end
      offset = cyc - pop_cyc;
      if (enc_init) begin
        init_cnt++;
        if (offset != 1) init_err++;
        if (enc_tail !== v.tail) tail_bad++;
      end
      if (!busy) busy_err++;
      if (offset >= 2 && bit_cnt !== CNT_W'(steps)) cnt_err++;
      if (gap_left > 0) begin
        if (enc_step) gap_err++;
        if (v.gap_kind == 2 && enc_bit !== fb[steps % 8]) hold_err++;
        gap_left--;
      end
      if (enc_step) begin
        if (enc_bit !== fb[steps % 8]) begin
          if (bit_err == 0) $display("  first bit error at step %0d", steps);
          bit_err++;
        end
        if (blk_rdreq !== ((steps % 8) == 7)) pop_err++;
        if (blk_rdreq) pops++;
        if (enc_last) begin
          last_cnt++;
          last_step = steps + 1;
        end
        steps++;
      end else if (blk_rdreq || enc_last) begin
        pop_err++;
      end
      if (abort_at >= 0 && steps == abort_at) begin
        force_empty = 1'b0;
        force_afull = 1'b0;
        do_abort(pops);
        return;
      end
      if (blk_done) begin
        done_seen    = 1;
        done_off     = offset;
        done_cnt     = bit_cnt;
        done_desc_rd = desc_rdreq;
        done_last    = enc_last;
`ifdef CONV_ENC_CTRL_TAIL_CHECK_EN
        done_terr    = tail_err;
`endif
      end
    end
    force_empty = 1'b0;
    force_afull = 1'b0;
    if (!done_seen) begin
      chk("block_timeout", 0, 1);
      return;
    end
    last_done_cyc = cyc;
    chk("init_pulse_count", init_cnt, 1);
    chk("init_one_after_pop", init_err, 0);
    chk("enc_tail_at_init", tail_bad, 0);
    chk("step_count", steps, v.exp_steps);
    chk("pop_count", pops, v.exp_pops);
    chk("bit_sequence_errs", bit_err, 0);
    chk("pop_alignment_errs", pop_err, 0);
    chk("enc_last_count", last_cnt, 1);
    chk("enc_last_step", last_step, v.exp_steps);
    chk("done_offset", done_off, v.exp_done_off);
    chk("bit_cnt_at_done", done_cnt, v.exp_steps);
    chk("desc_rdreq_in_done", done_desc_rd, 0);
    chk("enc_last_in_done", done_last, 0);
    chk("busy_errs", busy_err, 0);
    chk("bit_cnt_track_errs", cnt_err, 0);
    if (v.gap_kind != 0) chk("stall_step_errs", gap_err, 0);
    if (v.gap_kind == 2) chk("stall_bit_hold_errs", hold_err, 0);
`ifdef CONV_ENC_CTRL_TAIL_CHECK_EN
    chk("tail_err", done_terr, v.exp_tail_err);
`else
    chk("tail_err_absent", done_terr, 0);
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // size tail  fill  gap at len  steps pops done  tail_err
    vecs[0] = '{1'b0, 6'h2A, 8'hA5, 0, 0,   0,  1056, 132,  1058, 1'b1};
    vecs[1] = '{1'b1, 6'h15, 8'h3C, 0, 0,   0,  6144, 768,  6146, 1'b1};
    vecs[2] = '{1'b0, 6'h00, 8'hA5, 1, 403, 5,  1056, 132,  1063, 1'b1};
    vecs[3] = '{1'b0, 6'h29, 8'hA5, 2, 200, 10, 1056, 132,  1068, 1'b0};
    vecs[4] = '{1'b0, 6'h3F, 8'hFC, 0, 0,   0,  1056, 132,  1058, 1'b0};
    vecs[5] = '{1'b0, 6'h3E, 8'hFC, 0, 0,   0,  1056, 132,  1058, 1'b1};

    n_tests = 0; n_fail = 0; cyc = 0; last_done_cyc = 0;
    reset = 1'b0; rst_drive = 1'b0;
    force_empty = 1'b0; force_afull = 1'b0;
    desc_empty = 1'b1; desc_data = 7'h00;
    blk_empty = 1'b1; blk_data = 8'h00; out_afull = 1'b0;

    // Reset with a descriptor already waiting: nothing may be popped.
    push_block(0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst_desc_rdreq", desc_rdreq, 0);
      chk("rst_blk_rdreq", blk_rdreq, 0);
    end
    chk("rst_state_idle", state_dbg, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    chk("rst_enc_tail", enc_tail, 0);
    chk("rst_ctrl_pulses", {enc_init, enc_step, enc_bit, enc_last, blk_done}, 0);
    rst_drive = 1'b1;

    // Table-driven blocks.
    run_block(0, 1'b0, 1'b0, -1);
    for (int i = 1; i < 6; i++) run_block(i, 1'b1, 1'b0, -1);

    // Reset at bit_cnt=500, then a fresh block restarts from zero.
    run_block(0, 1'b1, 1'b0, 500);
    run_block(5, 1'b1, 1'b0, -1);

    // Back-to-back descriptors: minimum 3-cycle gap between blocks.
    push_block(0);
    push_block(4);
    run_block(0, 1'b0, 1'b0, -1);
    run_block(4, 1'b0, 1'b1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
